conv_window_gen: RTL and testbench

//  Consumer of the scratchpad_mem feature line buffer. Pops one K-pixel column per read from the

---
 rtl/conv_window_gen.sv | 121 ++++++++++++
 tb/tb_conv_window_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// conv_window_gen: pops K-pixel columns from the scratchpad lines into a KxK shift window
// and streams one stride-1 window per column to the PE array with valid/ready.
module conv_window_gen #(
    parameter int KERNEL_SIZE   = 5,
    parameter int FEATURE_WIDTH = 16,
    parameter int MAX_COLS      = 256,
    localparam int K            = KERNEL_SIZE,
    localparam int FW           = FEATURE_WIDTH,
    localparam int COL_W        = $clog2(MAX_COLS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [COL_W-1:0]    cfg_cols,
    input  logic [K*FW-1:0]     spad_data,
    input  logic                spad_empty,
    output logic                spad_rd_en,
    output logic [K*K*FW-1:0]   win_data,
    output logic                win_valid,
    output logic                win_last,
    input  logic                win_ready,
    output logic                busy,
    output logic                done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                      state_q, state_d;
    logic [COL_W-1:0]            cols_q, cols_d, issued_q, issued_d, loaded_q, loaded_d;
    logic                        rd_pend_q, rd_pend_d, hold_valid_q, hold_valid_d;
    logic [K-1:0][FW-1:0]        hold_q, hold_d, col_in, spad_col;
    logic [K-1:0][K-1:0][FW-1:0] win_q, win_d;
    logic                        win_valid_q, win_valid_d, win_last_q, win_last_d;
    logic                        can_shift, shift, accept, rd_en;

    assign spad_col   = spad_data;
    assign spad_rd_en = rd_en;
    assign win_data   = win_q;
    assign win_valid  = win_valid_q;
    assign win_last   = win_last_q;
    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;

    always_comb begin
        state_d      = state_q;
        cols_d       = cols_q;
        issued_d     = issued_q;
        loaded_d     = loaded_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        win_d        = win_q;
        win_valid_d  = win_valid_q;
        win_last_d   = win_last_q;
        can_shift    = !win_valid_q || win_ready;
        accept       = win_valid_q && win_ready;
        shift        = can_shift && (hold_valid_q || rd_pend_q);
        col_in       = hold_valid_q ? hold_q : spad_col;
        // A read is also held off when the column landing now must go to the hold buffer,
        // so a second column can never arrive while the buffer is occupied.
        rd_en        = state_q == RUN && !spad_empty && issued_q < cols_q && !hold_valid_q
                       && !(rd_pend_q && !can_shift);
        rd_pend_d    = rd_en;
        if (rd_en) issued_d = issued_q + COL_W'(1);
        if (rd_pend_q && !can_shift) begin
            hold_d       = spad_col;
            hold_valid_d = 1'b1;
        end else if (shift && hold_valid_q) begin
            hold_valid_d = 1'b0;
        end
        if (shift) begin
            for (int r = 0; r < K; r++) win_d[r] = {col_in[r], win_q[r][K-1:1]};
            loaded_d    = loaded_q + COL_W'(1);
            win_valid_d = loaded_q + COL_W'(1) >= COL_W'(K);
            win_last_d  = loaded_q + COL_W'(1) == cols_q;
        end else if (accept) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end
        case (state_q)
            IDLE: if (start) begin
                cols_d   = cfg_cols;
                issued_d = '0;
                loaded_d = '0;
                state_d  = cfg_cols < COL_W'(K) ? DONE : RUN;
            end
            RUN:   if (issued_q == cols_q) state_d = DRAIN;
            DRAIN: if (accept && win_last_q) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cols_q       <= '0;
            issued_q     <= '0;
            loaded_q     <= '0;
            rd_pend_q    <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cols_q       <= cols_d;
            issued_q     <= issued_d;
            loaded_q     <= loaded_d;
            rd_pend_q    <= rd_pend_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            win_last_q   <= win_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && start && state_q == IDLE)
            assert (cfg_cols <= COL_W'(MAX_COLS)) else $error("cfg_cols %0d exceeds MAX_COLS", cfg_cols);
    end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: table-driven sweeps against a scratchpad model, with a queue
// scoreboard of expected windows plus hand-written reset and short-row sequences.
module tb_conv_window_gen;
    localparam int K  = 5;
    localparam int FW = 16;
    localparam int W  = K * K * FW;

    typedef struct {
        int cols;
        int stall_after;
        bit tog;
        int rst_after;
        int nwin;
    } vec_t;
    typedef struct {
        logic [W-1:0] win;
        logic         last;
    } exp_t;

    logic            clk = 0, rst_n = 0, start = 0, spad_empty = 0, win_ready = 0;
    logic [8:0]      cfg_cols = '0;
    logic [K*FW-1:0] spad_data = '0;
    logic            spad_rd_en, win_valid, win_last, busy, done;
    logic [W-1:0]    win_data;
    int              nvec = 0, nerr = 0;
    exp_t            sb[$];
    vec_t            tbl[6];

    conv_window_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_cols(cfg_cols),
        .spad_data(spad_data), .spad_empty(spad_empty), .spad_rd_en(spad_rd_en),
        .win_data(win_data), .win_valid(win_valid), .win_last(win_last),
        .win_ready(win_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [K*FW-1:0] col_val(input int j);
        logic [K*FW-1:0] d;
        for (int i = 0; i < K; i++) d[i*FW +: FW] = FW'(16 * i + j);
        return d;
    endfunction

    function automatic logic [W-1:0] exp_win(input int n);
        logic [W-1:0] w;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) w[(r*K+c)*FW +: FW] = FW'(16 * r + n + c);
        return w;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rd_en"}, W'(spad_rd_en), '0);
        chk({tag, "_valid"}, W'(win_valid), '0);
        chk({tag, "_last"}, W'(win_last), '0);
        chk({tag, "_busy"}, W'(busy), '0);
        chk({tag, "_done"}, W'(done), '0);
        chk({tag, "_data"}, win_data, '0);
    endtask

    task automatic run_sweep(input vec_t v);
        int   col = 0, got = 0, stall = 0, cyc = 0, last_acc = 0;
        bit   pend = 0, seen_done = 0, exp_done = 0, held_v = 0;
        logic [W-1:0] held = '0;
        exp_t e;
        sb.delete();
        @(negedge clk);
        cfg_cols = 9'(v.cols);
        start = 1;
        win_ready = 1;
        spad_empty = 0;
        while (cyc < 300 && !seen_done) begin
            @(negedge clk);
            start = 0;
            cyc++;
            if (pend) begin
                spad_data = col_val(col);
                if (col >= K - 1) sb.push_back('{exp_win(col - K + 1), col == v.cols - 1});
                col++;
            end
            spad_empty = v.tog ? cyc[0] : 1'b0;
            win_ready = stall == 0;
            if (stall > 0) stall--;
            #1;
            if (spad_rd_en && spad_empty) chk("rd_en_while_empty", W'(spad_rd_en), '0);
            pend = spad_rd_en;
            if (held_v) begin
                chk("held_valid", W'(win_valid), W'(1));
                chk("held_data", win_data, held);
            end
            held_v = win_valid && !win_ready;
            held = win_data;
            if (exp_done) chk("done_after_last", W'(done), W'(1));
            if (done) seen_done = 1;
            if (win_valid && win_ready) begin
                if (sb.size() == 0) chk("unexpected_window", W'(got), W'(v.nwin));
                else begin
                    e = sb.pop_front();
                    chk($sformatf("win%0d_data", got), win_data, e.win);
                    chk($sformatf("win%0d_last", got), W'(win_last), W'(e.last));
                end
                if (got > 0 && v.stall_after < 0 && !v.tog) chk("back_to_back", W'(cyc - last_acc), W'(1));
                last_acc = cyc;
                exp_done = win_last;
                if (got == v.stall_after) stall = 3;
                if (got == v.rst_after) begin
                    rst_n = 0;
                    #1;
                    check_idle_outputs("async_rst");
                    @(negedge clk);
                    rst_n = 1;
                    spad_data = '0;
                    win_ready = 0;
                    return;
                end
                got++;
            end
        end
        chk("sweep_done_seen", W'(seen_done), W'(1));
        chk("window_count", W'(got), W'(v.nwin));
        chk("read_count", W'(col), W'(v.cols));
        chk("scoreboard_empty", W'(sb.size()), '0);
    endtask

    initial begin
        tbl[0] = '{5, -1, 0, -1, 1};
        tbl[1] = '{8, -1, 0, -1, 4};
        tbl[2] = '{8, 0, 0, -1, 4};
        tbl[3] = '{8, -1, 1, -1, 4};
        tbl[4] = '{8, -1, 0, 1, 0};
        tbl[5] = '{8, -1, 0, -1, 4};
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 4; i++) run_sweep(tbl[i]);
        @(negedge clk);
        cfg_cols = 9'd3;
        start = 1;
        #1;
        chk("short_rd_en", W'(spad_rd_en), '0);
        @(negedge clk);
        cfg_cols = 9'd8;
        #1;
        chk("short_done", W'(done), W'(1));
        chk("short_busy", W'(busy), W'(1));
        chk("short_valid", W'(win_valid), '0);
        chk("short_rd_en2", W'(spad_rd_en), '0);
        @(negedge clk);
        start = 0;
        #1;
        chk("short_done_clr", W'(done), '0);
        chk("short_idle", W'(busy), '0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("ignored_start_rd_en", W'(spad_rd_en), '0);
            chk("ignored_start_busy", W'(busy), '0);
        end
        for (int i = 4; i < 6; i++) run_sweep(tbl[i]);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
